// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, response codes, FSM states,
// and the request legality check.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } lsu_size_t;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_SIZE     = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } lsu_err_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_RESP = 2'b10
   } lsu_state_t;

   // An illegal size wins over misalignment, since alignment is undefined for it.
   function automatic lsu_err_t check_req(input lsu_size_t size, input logic [1:0] addr_lo);
      if (size == SZ_ILL) return ERR_SIZE;
      if ((size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00))
         return ERR_MISALIGN;
      return ERR_OK;
   endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Core-side request/response and memory-side bus signals of the load/store unit.
// The master modport is the LSU's view; slave is the core/memory environment.
interface lsu_bus_master_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic [1:0]        resp_err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between LSB-justified core data and a 32-bit memory word:
// store replication/strobes and load shift with sign or zero extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_size_t   size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] lane_wdata,
   output logic [3:0]  lane_wstrb,
   output logic [31:0] load_data
);
   logic [31:0] byte_rep;
   logic [31:0] half_rep;
   logic [31:0] shifted;

   // Replicating into every lane lets the strobes alone pick the target bytes.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_rep
         assign byte_rep[gi*8 +: 8] = wdata[7:0];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half_rep
         assign half_rep[gi*16 +: 16] = wdata[15:0];
      end
   endgenerate

   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      lane_wdata = wdata;
      lane_wstrb = 4'b0000;
      load_data  = shifted;
      case (size)
         SZ_BYTE: begin
            lane_wdata = byte_rep;
            lane_wstrb = 4'b0001 << offset;
            load_data  = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
         end
         SZ_HALF: begin
            lane_wdata = half_rep;
            lane_wstrb = 4'b0011 << offset;
            load_data  = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
         end
         SZ_WORD: begin
            lane_wstrb = 4'b1111;
         end
         default: begin
            lane_wstrb = 4'b0000;
            load_data  = '0;
         end
      endcase
   end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator: one byte/half/word access at a time onto a word-addressed bus.
// Define LSU_BUS_TIMEOUT_EN to abort bus waits of TIMEOUT_CYCLES cycles with ERR_TIMEOUT.
module lsu_bus_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   lsu_bus_master_if.master bus
);
   lsu_state_t        state_reg, state_next;
   logic              we_reg;
   lsu_size_t         size_reg;
   logic              unsigned_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   lsu_err_t          err_reg;
   logic [31:0]       rdata_reg;
   lsu_err_t          req_check;
   logic              accept;
   logic              capture;
   logic              timed_out;
   logic [31:0]       lane_wdata;
   logic [31:0]       load_data;
   logic [3:0]        lane_wstrb;

   assign req_check = check_req(lsu_size_t'(bus.req_size), bus.req_addr[1:0]);

   lsu_lane_align u_align (
      .size        (size_reg),
      .offset      (addr_reg[1:0]),
      .is_unsigned (unsigned_reg),
      .wdata       (wdata_reg),
      .rdata       (bus.mem_rdata),
      .lane_wdata  (lane_wdata),
      .lane_wstrb  (lane_wstrb),
      .load_data   (load_data)
   );

`ifdef LSU_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || state_reg != ST_BUS) wait_cnt_reg <= '0;
      else if (!bus.mem_ready)        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
   end

   // A mem_ready in the limit cycle completes normally instead of timing out.
   assign timed_out = (state_reg == ST_BUS) && !bus.mem_ready &&
                      (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // No bus-wait limit in this build; the expression is constant false.
   assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_reg       <= 1'b0;
         size_reg     <= SZ_BYTE;
         unsigned_reg <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         err_reg      <= ERR_OK;
         rdata_reg    <= '0;
      end else if (accept) begin
         we_reg       <= bus.req_we;
         size_reg     <= lsu_size_t'(bus.req_size);
         unsigned_reg <= bus.req_unsigned;
         addr_reg     <= bus.req_addr;
         wdata_reg    <= bus.req_wdata;
         err_reg      <= req_check;
         rdata_reg    <= '0;
      end else if (capture) begin
         rdata_reg    <= we_reg ? 32'h0 : load_data;
      end else if (timed_out) begin
         err_reg      <= ERR_TIMEOUT;
      end
   end

   always_comb begin
      state_next     = state_reg;
      accept         = 1'b0;
      capture        = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = '0;
      bus.resp_err   = ERR_OK;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.mem_wstrb  = '0;
      unique case (state_reg)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept     = 1'b1;
               state_next = (req_check == ERR_OK) ? ST_BUS : ST_RESP;
            end
         end
         ST_BUS: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we_reg;
            bus.mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
            bus.mem_wdata = we_reg ? lane_wdata : 32'h0;
            bus.mem_wstrb = we_reg ? lane_wstrb : 4'b0000;
            if (bus.mem_ready) begin
               capture    = 1'b1;
               state_next = ST_RESP;
            end else if (timed_out) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = rdata_reg;
            bus.resp_err   = err_reg;
            state_next     = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed scenarios plus a short random
// back-to-back run, with expected responses queued at issue time.
module tb_lsu_bus_master;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_bus_master_if #(.ADDR_W(32)) bif ();

   lsu_bus_master #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          lat;
      int          reqs;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [3:0]  wstrb;
      logic        mwe;
      logic        stable;
      logic        ready;
      logic        pulse2;
      logic        ready_after;
   } txn_t;

   txn_t sb[$];
   int n_vec = 0;
   int n_bad = 0;

   function automatic txn_t mk_exp(logic [31:0] rdata, logic [1:0] err, int lat, int reqs,
                                   logic [31:0] maddr, logic [31:0] mwdata, logic [3:0] wstrb, logic mwe);
      txn_t t;
      t = '{default: 0};
      t.rdata = rdata; t.err = err; t.lat = lat; t.reqs = reqs;
      t.maddr = maddr; t.mwdata = mwdata; t.wstrb = wstrb; t.mwe = mwe;
      t.stable = 1'b1; t.ready = 1'b1; t.pulse2 = 1'b0; t.ready_after = 1'b1;
      return t;
   endfunction

   // Byte-level reference for legal requests: lane i of a store carries data byte i mod n.
   function automatic txn_t model(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                  logic [31:0] wdata, logic [31:0] rd, int stall);
      txn_t t;
      int n;
      int off;
      logic [31:0] val;
      logic [31:0] wd;
      logic [3:0]  st;
      n = 1 << size;
      off = int'(addr[1:0]);
      val = 32'h0; wd = 32'h0; st = 4'b0000;
      for (int i = 0; i < n; i++) val[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!uns && val[8*n-1])
         for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         wd[8*i +: 8] = wdata[8*(i % n) +: 8];
         st[i] = (i >= off) && (i < off + n);
      end
      t = mk_exp(we ? 32'h0 : val, 2'b00, 2 + stall, 1 + stall, {addr[31:2], 2'b00},
                 wd, we ? st : 4'b0000, we);
      return t;
   endfunction

   // Issues one request, services the bus after `stall` wait cycles (never if negative)
   // and records what the DUT did; bounded at 64 cycles.
   task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int stall, output txn_t obs);
      int req_cnt;
      req_cnt = 0;
      obs = '{default: 0};
      obs.lat = -1;
      obs.stable = 1'b1;
      bif.req_valid = 1'b1; bif.req_we = we; bif.req_size = size;
      bif.req_unsigned = uns; bif.req_addr = addr; bif.req_wdata = wdata;
      obs.ready = bif.req_ready;
      @(negedge clk);
      bif.req_valid = 1'b0;
      for (int c = 1; c <= 64; c++) begin
         if (bif.resp_valid) begin
            obs.lat = c; obs.rdata = bif.resp_rdata; obs.err = bif.resp_err;
            break;
         end
         if (bif.mem_req) begin
            if (req_cnt == 0) begin
               obs.maddr = bif.mem_addr; obs.mwdata = bif.mem_wdata;
               obs.wstrb = bif.mem_wstrb; obs.mwe = bif.mem_we;
            end else if ({obs.maddr, obs.mwdata, obs.wstrb, obs.mwe} !==
                         {bif.mem_addr, bif.mem_wdata, bif.mem_wstrb, bif.mem_we}) begin
               obs.stable = 1'b0;
            end
            req_cnt++;
            bif.mem_ready = (stall >= 0) && (req_cnt > stall);
            bif.mem_rdata = rd;
         end else begin
            bif.mem_ready = 1'b0;
         end
         @(negedge clk);
      end
      bif.mem_ready = 1'b0;
      bif.mem_rdata = 32'h0;
      obs.reqs = req_cnt;
      @(negedge clk);
      obs.pulse2 = bif.resp_valid;
      obs.ready_after = bif.req_ready;
   endtask

   task automatic test_reset();
      bif.req_valid = 0; bif.req_we = 0; bif.req_size = 0; bif.req_unsigned = 0;
      bif.req_addr = 0; bif.req_wdata = 0; bif.mem_ready = 0; bif.mem_rdata = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (bif.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", bif.req_ready); end
      n_vec++; if ({bif.resp_valid, bif.mem_req, bif.mem_we, bif.resp_err, bif.mem_wstrb} !== 9'h0) begin
         n_bad++; $display("FAIL reset_ctrl got %b want 0", {bif.resp_valid, bif.mem_req, bif.mem_we, bif.resp_err, bif.mem_wstrb});
      end
      n_vec++; if ({bif.mem_addr, bif.mem_wdata, bif.resp_rdata} !== 96'h0) begin
         n_bad++; $display("FAIL reset_data got %h/%h/%h want 0", bif.mem_addr, bif.mem_wdata, bif.resp_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_signed_byte_load();
      txn_t obs, e;
      sb.push_back(mk_exp(32'hFFFFFF80, 2'b00, 2, 1, 32'h00000100, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b00, 1'b0, 32'h00000103, 32'h0, 32'h80AABBCC, 0, obs);
      e = sb.pop_front();
      n_vec++; if (obs.rdata !== e.rdata) begin n_bad++; $display("FAIL sbyte_rdata got %h want %h", obs.rdata, e.rdata); end
      n_vec++; if (obs.err !== e.err) begin n_bad++; $display("FAIL sbyte_err got %b want %b", obs.err, e.err); end
      n_vec++; if (obs.lat !== e.lat) begin n_bad++; $display("FAIL sbyte_latency got %0d want %0d", obs.lat, e.lat); end
      n_vec++; if (obs.maddr !== e.maddr) begin n_bad++; $display("FAIL sbyte_mem_addr got %h want %h", obs.maddr, e.maddr); end
      n_vec++; if ({obs.mwe, obs.wstrb} !== {e.mwe, e.wstrb}) begin n_bad++; $display("FAIL sbyte_we_wstrb got %b want %b", {obs.mwe, obs.wstrb}, {e.mwe, e.wstrb}); end
      n_vec++; if ({obs.pulse2, obs.ready_after} !== 2'b01) begin n_bad++; $display("FAIL sbyte_pulse got %b want 01", {obs.pulse2, obs.ready_after}); end
   endtask

   task automatic test_stores();
      txn_t obs, e;
      sb.push_back(mk_exp(32'h0, 2'b00, 5, 4, 32'h00000200, 32'hA5A5A5A5, 4'b0100, 1'b1));
      run_txn(1'b1, 2'b00, 1'b0, 32'h00000202, 32'h000000A5, 32'hDEADBEEF, 3, obs);
      e = sb.pop_front();
      n_vec++; if (obs.mwdata !== e.mwdata) begin n_bad++; $display("FAIL bstore_wdata got %h want %h", obs.mwdata, e.mwdata); end
      n_vec++; if ({obs.mwe, obs.wstrb} !== {e.mwe, e.wstrb}) begin n_bad++; $display("FAIL bstore_we_wstrb got %b want %b", {obs.mwe, obs.wstrb}, {e.mwe, e.wstrb}); end
      n_vec++; if (obs.reqs !== e.reqs || obs.stable !== 1'b1) begin n_bad++; $display("FAIL bstore_hold got %0d cycles stable=%b want %0d stable=1", obs.reqs, obs.stable, e.reqs); end
      n_vec++; if ({obs.rdata, obs.err} !== {e.rdata, e.err}) begin n_bad++; $display("FAIL bstore_resp got %h/%b want %h/%b", obs.rdata, obs.err, e.rdata, e.err); end
      n_vec++; if (obs.lat !== e.lat) begin n_bad++; $display("FAIL bstore_latency got %0d want %0d", obs.lat, e.lat); end
      sb.push_back(mk_exp(32'h0, 2'b00, 2, 1, 32'h00000200, 32'h12341234, 4'b1100, 1'b1));
      run_txn(1'b1, 2'b01, 1'b0, 32'h00000202, 32'h00001234, 32'h0, 0, obs);
      e = sb.pop_front();
      n_vec++; if (obs.mwdata !== e.mwdata) begin n_bad++; $display("FAIL hstore_wdata got %h want %h", obs.mwdata, e.mwdata); end
      n_vec++; if (obs.wstrb !== e.wstrb) begin n_bad++; $display("FAIL hstore_wstrb got %b want %b", obs.wstrb, e.wstrb); end
   endtask

   task automatic test_errors();
      txn_t obs, e;
      sb.push_back(mk_exp(32'h0, 2'b01, 1, 0, 32'h0, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0, 32'hFFFFFFFF, 0, obs);
      e = sb.pop_front();
      n_vec++; if (obs.err !== e.err) begin n_bad++; $display("FAIL misalign_err got %b want %b", obs.err, e.err); end
      n_vec++; if (obs.lat !== e.lat || obs.reqs !== e.reqs) begin n_bad++; $display("FAIL misalign_timing got lat %0d bus %0d want lat %0d bus %0d", obs.lat, obs.reqs, e.lat, e.reqs); end
      n_vec++; if (obs.rdata !== e.rdata) begin n_bad++; $display("FAIL misalign_rdata got %h want %h", obs.rdata, e.rdata); end
      sb.push_back(mk_exp(32'h0, 2'b10, 1, 0, 32'h0, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b11, 1'b0, 32'h00000006, 32'h0, 32'hFFFFFFFF, 0, obs);
      e = sb.pop_front();
      n_vec++; if ({obs.err, obs.rdata} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL illsize_resp got %b/%h want %b/%h", obs.err, obs.rdata, e.err, e.rdata); end
      n_vec++; if (obs.reqs !== e.reqs) begin n_bad++; $display("FAIL illsize_bus got %0d want %0d", obs.reqs, e.reqs); end
      sb.push_back(mk_exp(32'h0, 2'b01, 1, 0, 32'h0, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b1, 2'b01, 1'b0, 32'h00000001, 32'h5555, 32'h0, 0, obs);
      e = sb.pop_front();
      n_vec++; if ({obs.err, obs.reqs} !== {e.err, e.reqs}) begin n_bad++; $display("FAIL half_odd got %b/%0d want %b/%0d", obs.err, obs.reqs, e.err, e.reqs); end
   endtask

   task automatic test_half_loads();
      txn_t obs, e;
      sb.push_back(mk_exp(32'h0000FEDC, 2'b00, 2, 1, 32'h0, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b01, 1'b1, 32'h00000002, 32'h0, 32'hFEDC0000, 0, obs);
      e = sb.pop_front();
      n_vec++; if (obs.rdata !== e.rdata) begin n_bad++; $display("FAIL uhalf_rdata got %h want %h", obs.rdata, e.rdata); end
      sb.push_back(mk_exp(32'hFFFFFEDC, 2'b00, 2, 1, 32'h0, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b01, 1'b0, 32'h00000002, 32'h0, 32'hFEDC0000, 0, obs);
      e = sb.pop_front();
      n_vec++; if (obs.rdata !== e.rdata) begin n_bad++; $display("FAIL shalf_rdata got %h want %h", obs.rdata, e.rdata); end
   endtask

   task automatic test_reset_mid_bus();
      txn_t obs, e;
      bit seen;
      bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_size = 2'b10;
      bif.req_unsigned = 1'b0; bif.req_addr = 32'h00000040; bif.req_wdata = 32'h0;
      @(negedge clk);
      bif.req_valid = 1'b0;
      n_vec++; if (bif.mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_bus_entry got %b want 1", bif.mem_req); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if ({bif.mem_req, bif.req_ready} !== 2'b01) begin n_bad++; $display("FAIL rstmid_state got %b want 01", {bif.mem_req, bif.req_ready}); end
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (bif.resp_valid) seen = 1'b1;
         @(negedge clk);
      end
      n_vec++; if (seen) begin n_bad++; $display("FAIL rstmid_resp got 1 want 0"); end
      sb.push_back(mk_exp(32'h13579BDF, 2'b00, 2, 1, 32'hEEEE0000, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b10, 1'b0, 32'hEEEE0000, 32'h0, 32'h13579BDF, 0, obs);
      e = sb.pop_front();
      n_vec++; if ({obs.rdata, obs.err} !== {e.rdata, e.err}) begin n_bad++; $display("FAIL rstmid_after_resp got %h/%b want %h/%b", obs.rdata, obs.err, e.rdata, e.err); end
      n_vec++; if (obs.maddr !== e.maddr || obs.lat !== e.lat) begin n_bad++; $display("FAIL rstmid_after_bus got %h lat %0d want %h lat %0d", obs.maddr, obs.lat, e.maddr, e.lat); end
   endtask

   task automatic test_back_to_back();
      txn_t obs, e;
      logic we, uns;
      logic [1:0] size;
      logic [31:0] addr, wdata, rd;
      int stall;
      for (int k = 0; k < 10; k++) begin
         we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 2));
         addr = $urandom; wdata = $urandom; rd = $urandom;
         stall = $urandom_range(0, 2);
         if (size == 2'b01) addr[0] = 1'b0;
         if (size == 2'b10) addr[1:0] = 2'b00;
         sb.push_back(model(we, size, uns, addr, wdata, rd, stall));
         run_txn(we, size, uns, addr, wdata, rd, stall, obs);
         e = sb.pop_front();
         n_vec++; if ({obs.rdata, obs.err} !== {e.rdata, e.err}) begin n_bad++; $display("FAIL b2b[%0d] resp got %h/%b want %h/%b", k, obs.rdata, obs.err, e.rdata, e.err); end
         n_vec++; if ({obs.maddr, obs.mwe, obs.wstrb} !== {e.maddr, e.mwe, e.wstrb}) begin n_bad++; $display("FAIL b2b[%0d] bus got %h/%b/%b want %h/%b/%b", k, obs.maddr, obs.mwe, obs.wstrb, e.maddr, e.mwe, e.wstrb); end
         if (we) begin
            n_vec++; if (obs.mwdata !== e.mwdata) begin n_bad++; $display("FAIL b2b[%0d] wdata got %h want %h", k, obs.mwdata, e.mwdata); end
         end
         n_vec++; if (obs.lat !== e.lat || obs.ready !== 1'b1) begin n_bad++; $display("FAIL b2b[%0d] timing got lat %0d ready %b want lat %0d ready 1", k, obs.lat, obs.ready, e.lat); end
      end
   endtask

`ifdef LSU_BUS_TIMEOUT_EN
   task automatic test_timeout();
      txn_t obs, e;
      sb.push_back(mk_exp(32'h0, 2'b11, 17, 16, 32'h00000300, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 32'hCAFEF00D, -1, obs);
      e = sb.pop_front();
      n_vec++; if ({obs.err, obs.rdata} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL timeout_resp got %b/%h want %b/%h", obs.err, obs.rdata, e.err, e.rdata); end
      n_vec++; if (obs.reqs !== e.reqs || obs.lat !== e.lat) begin n_bad++; $display("FAIL timeout_timing got bus %0d lat %0d want bus %0d lat %0d", obs.reqs, obs.lat, e.reqs, e.lat); end
      sb.push_back(mk_exp(32'hCAFEF00D, 2'b00, 17, 16, 32'h00000300, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 32'hCAFEF00D, 15, obs);
      e = sb.pop_front();
      n_vec++; if ({obs.err, obs.rdata} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL timeout_edge got %b/%h want %b/%h", obs.err, obs.rdata, e.err, e.rdata); end
   endtask
`else
   task automatic test_timeout();
      txn_t obs, e;
      sb.push_back(mk_exp(32'h0BADF00D, 2'b00, 22, 21, 32'h00000300, 32'h0, 4'b0000, 1'b0));
      run_txn(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 32'h0BADF00D, 20, obs);
      e = sb.pop_front();
      n_vec++; if ({obs.err, obs.rdata} !== {e.err, e.rdata}) begin n_bad++; $display("FAIL long_wait_resp got %b/%h want %b/%h", obs.err, obs.rdata, e.err, e.rdata); end
      n_vec++; if (obs.reqs !== e.reqs || obs.lat !== e.lat) begin n_bad++; $display("FAIL long_wait_timing got bus %0d lat %0d want bus %0d lat %0d", obs.reqs, obs.lat, e.reqs, e.lat); end
   endtask
`endif

   initial begin
      test_reset();
      test_signed_byte_load();
      test_stores();
      test_errors();
      test_half_loads();
      test_reset_mid_bus();
      test_back_to_back();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1);
   end

endmodule
